// File: rtl/div_pkg.sv
// Shared constants and ratio legality check for the pulse-swallow divider.
package div_pkg;
  localparam int P_WIDTH_DEF = 6;
  localparam int S_WIDTH_DEF = 4;
  localparam int P_MIN = 2;

  function automatic logic ratio_legal(
    input logic [31:0] p,
    input logic [31:0] s
  );
    return (p >= 32'(P_MIN)) && (s <= p);
  endfunction
endpackage

// File: rtl/ratio_shadow.sv
// Shadow P/S register behind a valid/ready handshake with legality check.
module ratio_shadow
  import div_pkg::*;
#(
  parameter int P_WIDTH = P_WIDTH_DEF,
  parameter int S_WIDTH = S_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  input  logic [P_WIDTH-1:0] cfg_p,
  input  logic [S_WIDTH-1:0] cfg_s,
  input  logic               wrap,
  output logic               cfg_ready,
  output logic               cfg_err,
  output logic               sh_full,
  output logic [P_WIDTH-1:0] sh_p,
  output logic [S_WIDTH-1:0] sh_s,
  output logic               acc_legal
);
  logic legal;
  logic take;

  assign legal     = ratio_legal(32'(cfg_p), 32'(cfg_s));
  assign cfg_ready = !sh_full;
  assign take      = cfg_valid && cfg_ready;
  assign acc_legal = take && legal;

  // A legal offer landing on the wrap goes straight to the active ratio.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_full <= 1'b0;
      cfg_err <= 1'b0;
      sh_p    <= '0;
      sh_s    <= '0;
    end else begin
      cfg_err <= take && !legal;
      if (acc_legal && !wrap) begin
        sh_full <= 1'b1;
        sh_p    <= cfg_p;
        sh_s    <= cfg_s;
      end else if (wrap) begin
        sh_full <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/pulse_swallow_ctrl.sv
// Pulse-swallow divider controller: period counter, ratio update and decode.
module pulse_swallow_ctrl
  import div_pkg::*;
#(
  parameter int P_WIDTH = P_WIDTH_DEF,
  parameter int S_WIDTH = S_WIDTH_DEF,
  parameter int P_RST   = 7,
  parameter int S_RST   = 3
) (
  input  logic               Fin,
  input  logic               rst,
  input  logic               en,
  input  logic               cfg_valid,
  input  logic [P_WIDTH-1:0] cfg_p,
  input  logic [S_WIDTH-1:0] cfg_s,
  output logic               cfg_ready,
  output logic               cfg_err,
  output logic               mc_o,
  output logic               fout_o,
  output logic               ld_o,
  output logic [P_WIDTH-1:0] p_act,
  output logic [S_WIDTH-1:0] s_act
);
  localparam int CW = ((P_WIDTH > S_WIDTH) ? P_WIDTH : S_WIDTH) + 1;
  localparam logic [P_WIDTH-1:0] P_ONE = 1;

  logic [P_WIDTH-1:0] idx;
  logic [P_WIDTH-1:0] nk;
  logic [P_WIDTH-1:0] np;
  logic [S_WIDTH-1:0] ns;
  logic [CW-1:0]      half;
  logic               last;
  logic               wrap;
  logic               mc_n;
  logic               fo_n;
  logic               ld_n;
  logic               sh_full;
  logic [P_WIDTH-1:0] sh_p;
  logic [S_WIDTH-1:0] sh_s;
  logic               acc_legal;

  ratio_shadow #(
    .P_WIDTH(P_WIDTH),
    .S_WIDTH(S_WIDTH)
  ) u_shadow (
    .clk      (Fin),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_p    (cfg_p),
    .cfg_s    (cfg_s),
    .wrap     (wrap),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .sh_full  (sh_full),
    .sh_p     (sh_p),
    .sh_s     (sh_s),
    .acc_legal(acc_legal)
  );

  // Outputs are decoded from the next state so they line up with idx.
  always_comb begin
    last = (idx == p_act - P_ONE);
    wrap = en && last;
    nk   = last ? '0 : idx + P_ONE;
    np   = p_act;
    ns   = s_act;
    if (wrap && sh_full) begin
      np = sh_p;
      ns = sh_s;
    end else if (wrap && acc_legal) begin
      np = cfg_p;
      ns = cfg_s;
    end
    half = (CW'(np) + CW'(1)) >> 1;
    mc_n = CW'(nk) < CW'(ns);
    fo_n = CW'(nk) < half;
    ld_n = (nk == np - P_ONE);
  end

  always_ff @(posedge Fin) begin
    if (rst) begin
      idx    <= '0;
      p_act  <= P_WIDTH'(P_RST);
      s_act  <= S_WIDTH'(S_RST);
      mc_o   <= (S_RST != 0);
      fout_o <= 1'b1;
      ld_o   <= 1'b0;
    end else if (en) begin
      idx    <= nk;
      p_act  <= np;
      s_act  <= ns;
      mc_o   <= mc_n;
      fout_o <= fo_n;
      ld_o   <= ld_n;
    end else begin
      ld_o   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pulse_swallow_ctrl.sv
// Directed vector bench for pulse_swallow_ctrl.
module tb_pulse_swallow_ctrl;
  import div_pkg::*;

  logic       Fin = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [5:0] cfg_p = '0;
  logic [3:0] cfg_s = '0;
  logic       cfg_ready;
  logic       cfg_err;
  logic       mc_o;
  logic       fout_o;
  logic       ld_o;
  logic [5:0] p_act;
  logic [3:0] s_act;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       cv;
    logic [5:0] cp;
    logic [3:0] cs;
    logic       mc;
    logic       fo;
    logic       ld;
    logic       rdy;
    logic       err;
    logic [5:0] p;
    logic [3:0] s;
  } vec_t;

  vec_t tbl[$];

  pulse_swallow_ctrl dut (
    .Fin      (Fin),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_p    (cfg_p),
    .cfg_s    (cfg_s),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .mc_o     (mc_o),
    .fout_o   (fout_o),
    .ld_o     (ld_o),
    .p_act    (p_act),
    .s_act    (s_act)
  );

  always #5 Fin = ~Fin;

  function automatic void t(
    input int r, input int e, input int cv, input int cp, input int cs,
    input int mc, input int fo, input int ld, input int rdy, input int err,
    input int p, input int s
  );
    vec_t v;
    v.rst = 1'(r);
    v.en = 1'(e);
    v.cv = 1'(cv);
    v.cp = 6'(cp);
    v.cs = 4'(cs);
    v.mc = 1'(mc);
    v.fo = 1'(fo);
    v.ld = 1'(ld);
    v.rdy = 1'(rdy);
    v.err = 1'(err);
    v.p = 6'(p);
    v.s = 4'(s);
    tbl.push_back(v);
  endfunction

  task automatic chk(
    input string name, input int id,
    input logic [31:0] act, input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d want %0d", name, id, act, exp);
    end
  endtask

  task automatic chk_out(
    input int id, input logic mc, input logic fo, input logic ld,
    input logic rdy, input logic [5:0] p, input logic [3:0] s
  );
    chk("mc_o", id, 32'(mc_o), 32'(mc));
    chk("fout_o", id, 32'(fout_o), 32'(fo));
    chk("ld_o", id, 32'(ld_o), 32'(ld));
    chk("cfg_ready", id, 32'(cfg_ready), 32'(rdy));
    chk("p_act", id, 32'(p_act), 32'(p));
    chk("s_act", id, 32'(s_act), 32'(s));
  endtask

  task automatic step(input logic e);
    rst = 1'b0;
    en = e;
    cfg_valid = 1'b0;
    @(posedge Fin);
    @(negedge Fin);
  endtask

  initial begin
    // reset, then default 7/3 for 21 cycles
    t(1,1,0,0,0, 1,1,0,1,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    t(0,1,0,0,0, 0,1,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,1,1,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    t(0,1,0,0,0, 0,1,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,1,1,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    t(0,1,0,0,0, 0,1,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,1,1,0,7,3);
    // illegal offers 4/5 (on the boundary) and 1/0
    t(0,1,1,4,5, 1,1,0,1,1,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    t(0,1,1,1,0, 1,1,0,1,1,7,3);
    t(0,1,0,0,0, 0,1,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,1,1,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    // mid-period offer 10/5 at k=2
    t(0,1,1,10,5, 0,1,0,0,0,7,3);
    t(0,1,0,0,0, 0,0,0,0,0,7,3);
    t(0,1,0,0,0, 0,0,0,0,0,7,3);
    t(0,1,0,0,0, 0,0,1,0,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,10,5);
    t(0,1,0,0,0, 1,1,0,1,0,10,5);
    t(0,1,0,0,0, 1,1,0,1,0,10,5);
    t(0,1,0,0,0, 1,1,0,1,0,10,5);
    t(0,1,0,0,0, 1,1,0,1,0,10,5);
    t(0,1,0,0,0, 0,0,0,1,0,10,5);
    t(0,1,0,0,0, 0,0,0,1,0,10,5);
    t(0,1,0,0,0, 0,0,0,1,0,10,5);
    t(0,1,0,0,0, 0,0,0,1,0,10,5);
    t(0,1,0,0,0, 0,0,1,1,0,10,5);
    // legal 2/2 on the ld cycle bypasses the shadow
    t(0,1,1,2,2, 1,1,0,1,0,2,2);
    t(0,1,0,0,0, 1,0,1,1,0,2,2);
    t(0,1,0,0,0, 1,1,0,1,0,2,2);
    t(0,1,0,0,0, 1,0,1,1,0,2,2);
    t(0,1,0,0,0, 1,1,0,1,0,2,2);
    // back to 7/3, then en low at k=3 for 5 cycles
    t(0,1,1,7,3, 1,0,1,0,0,2,2);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    t(0,1,0,0,0, 0,1,0,1,0,7,3);
    t(0,0,0,0,0, 0,1,0,1,0,7,3);
    t(0,0,0,0,0, 0,1,0,1,0,7,3);
    t(0,0,0,0,0, 0,1,0,1,0,7,3);
    t(0,0,0,0,0, 0,1,0,1,0,7,3);
    t(0,0,0,0,0, 0,1,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,1,1,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    // fill shadow, then reset at k=4 with an illegal offer present
    t(0,1,1,10,5, 1,1,0,0,0,7,3);
    t(0,1,0,0,0, 1,1,0,0,0,7,3);
    t(0,1,0,0,0, 0,1,0,0,0,7,3);
    t(0,1,0,0,0, 0,0,0,0,0,7,3);
    t(1,1,1,1,0, 1,1,0,1,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    t(0,1,0,0,0, 0,1,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,0,1,0,7,3);
    t(0,1,0,0,0, 0,0,1,1,0,7,3);
    t(0,1,0,0,0, 1,1,0,1,0,7,3);
    // S=0 ratio 3/0: mc never asserts
    t(0,1,1,3,0, 1,1,0,0,0,7,3);
    t(0,1,0,0,0, 1,1,0,0,0,7,3);
    t(0,1,0,0,0, 0,1,0,0,0,7,3);
    t(0,1,0,0,0, 0,0,0,0,0,7,3);
    t(0,1,0,0,0, 0,0,0,0,0,7,3);
    t(0,1,0,0,0, 0,0,1,0,0,7,3);
    t(0,1,0,0,0, 0,1,0,1,0,3,0);
    t(0,1,0,0,0, 0,1,0,1,0,3,0);
    t(0,1,0,0,0, 0,0,1,1,0,3,0);
    t(0,1,0,0,0, 0,1,0,1,0,3,0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      en = tbl[i].en;
      cfg_valid = tbl[i].cv;
      cfg_p = tbl[i].cp;
      cfg_s = tbl[i].cs;
      @(posedge Fin);
      @(negedge Fin);
      chk_out(i, tbl[i].mc, tbl[i].fo, tbl[i].ld,
              tbl[i].rdy, tbl[i].p, tbl[i].s);
      chk("cfg_err", i, 32'(cfg_err), 32'(tbl[i].err));
    end

    // en dropped on the ld cycle: ld clears, wrap happens on resume
    step(1'b1);
    chk_out(1000, 1'b0, 1'b1, 1'b0, 1'b1, 6'd3, 4'd0);
    step(1'b1);
    chk_out(1001, 1'b0, 1'b0, 1'b1, 1'b1, 6'd3, 4'd0);
    step(1'b0);
    chk_out(1002, 1'b0, 1'b0, 1'b0, 1'b1, 6'd3, 4'd0);
    step(1'b0);
    chk_out(1003, 1'b0, 1'b0, 1'b0, 1'b1, 6'd3, 4'd0);
    step(1'b1);
    chk_out(1004, 1'b0, 1'b1, 1'b0, 1'b1, 6'd3, 4'd0);
    step(1'b1);
    chk_out(1005, 1'b0, 1'b1, 1'b0, 1'b1, 6'd3, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_swallow_ctrl.md
Name: pulse_swallow_ctrl

Overview:
- Parametrised successor to the separate P/S counter pair: a single controller for the pulse-swallow divider, clocked by the prescaler output `Fin`.
- Per division period it produces:
  - the modulus-control pulse train for an N/N+1 prescaler;
  - the divided output clock;
  - a period-end load strobe.
- Adds what the old pair lacks:
  - double-buffered P/S reprogramming through a valid/ready handshake, applied only at a period boundary, so ratio changes are glitch-free;
  - ratio legality checking;
  - a run enable.
- Overall divide ratio = P*N + S, where N is the prescaler's base modulus.

Parameters:
P_WIDTH, 6, width of P (period length in Fin cycles)
S_WIDTH, 4, width of S (swallow count)
P_RST, 7, active P after reset (must satisfy 2 <= P_RST < 2**P_WIDTH)
S_RST, 3, active S after reset (must satisfy S_RST <= P_RST)

Ports:
Fin  in  1  clock (prescaler output)
rst  in  1  synchronous active-high reset
en  in  1  run enable
cfg_valid  in  1  new ratio offered
cfg_p  in  P_WIDTH  requested P
cfg_s  in  S_WIDTH  requested S
cfg_ready  out  1  shadow register empty; offer will be taken
cfg_err  out  1  one-cycle pulse: offered ratio rejected
mc_o  out  1  modulus control (1 = prescaler divides by N+1)
fout_o  out  1  divided output
ld_o  out  1  last cycle of the current period
p_act  out  P_WIDTH  P currently in force
s_act  out  S_WIDTH  S currently in force

Behaviour:
- State registers:
  - idx, a P_WIDTH-bit period index;
  - P_act and S_act;
  - shadow P/S plus a shadow_full flag.
- Outputs mc_o, fout_o and ld_o are registered. For period cycle k (k = 0..P_act-1):
  - mc_o = (k < S_act);
  - fout_o = (k < (P_act+1)>>1);
  - ld_o = (k == P_act-1).
- Reset, applied at the next Fin edge whenever rst=1, including mid-period:
  - idx=0, P_act=P_RST, S_act=S_RST, shadow_full=0, cfg_err=0, ld_o=0;
  - mc_o=(S_RST>0), fout_o=1.
  - The first cycle after rst deasserts is k=0.
- en=1:
  - idx increments each Fin edge.
  - At k == P_act-1, idx wraps to 0 (period boundary).
  - On wrap, if shadow_full, P_act/S_act load from the shadow and shadow_full clears.
  - Outputs for k=0 of the new period reflect the new ratio.
- en=0:
  - idx, P_act and S_act hold; mc_o and fout_o hold; ld_o=0.
  - The handshake stays active.
  - Resuming continues from the held k.
- Handshake:
  - cfg_ready = !shadow_full (combinational from the register).
  - Transfer happens when cfg_valid && cfg_ready.
  - Legal ratio: 2 <= cfg_p and cfg_s <= cfg_p, with cfg_s zero-extended for the comparison.
  - Legal transfer: shadow loads and shadow_full sets.
  - Illegal transfer: shadow unchanged, cfg_err=1 for exactly one cycle, cfg_ready stays 1.
- Transfer coinciding with a boundary:
  - A legal transfer on the cycle where ld_o=1, with shadow empty and en=1, bypasses the shadow.
  - P_act/S_act take cfg_p/cfg_s at that wrap, and shadow_full stays 0.
- Shadow full at a boundary: cfg_ready=0 that cycle, so no collision is possible.
- Edge ratios:
  - S_act=0: mc_o never asserts.
  - S_act=P_act: mc_o is high for the whole period.
  - P_act=2: ld_o asserts every second cycle.
- Width: all comparisons are unsigned and P_WIDTH wide; no arithmetic overflow is possible because P_act <= 2**P_WIDTH-1.

Decomposition:
- Shared package `div_pkg`: P_WIDTH/S_WIDTH defaults, P_MIN=2, and a legality-check function used by both RTL and bench.
- One natural sub-module, `ratio_shadow`: holds the shadow register, shadow_full, the legality check and cfg_err. The period counter and output decode stay in the top level.

Test Plan:
- Reset default (P=7, S=3), en=1, 21 cycles:
  - mc_o pattern 1110000 repeats 3 times;
  - fout_o pattern 1111000;
  - ld_o high at k=6, 13, 20.
- Mid-period cfg_p=10, cfg_s=5 offered at k=2:
  - cfg_ready drops next cycle;
  - current period finishes with 7/3;
  - next period is 10 cycles with mc_o high 5 cycles;
  - cfg_ready returns at the wrap.
- Offer cfg_p=4, cfg_s=5 (illegal), then cfg_p=1, cfg_s=0 (illegal):
  - cfg_err pulses once per offer;
  - p_act/s_act remain 7/3;
  - cfg_ready stays 1.
- Legal offer cfg_p=2, cfg_s=2 on the ld_o cycle:
  - the very next period uses 2/2;
  - mc_o is constantly 1 and ld_o toggles every other cycle.
- en dropped at k=3 for 5 cycles: outputs freeze, ld_o=0; on resume, k=4 follows and the period completes in 7 enabled cycles.
- rst asserted at k=4 with shadow_full=1:
  - next cycle shows k=0 with 7/3;
  - shadow is discarded (cfg_ready=1) and cfg_err=0.
